// File: rtl/uart_word_loader.sv
// Packs received UART bytes little-endian into 32-bit words and writes them to
// instruction memory at consecutive word addresses; an idle-line timeout ends the load.
module uart_word_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  load_en,
  input  logic                  uart_done,
  input  logic [7:0]            uart_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 done_q;
  logic [1:0]           byte_idx;
  logic [31:0]          word_buf;
  logic [TIMER_W-1:0]   timer_q;
  logic                 byte_edge;
  logic                 accept;
  logic                 flush;
  logic                 clear;
  logic [ADDR_WIDTH:0]  count_next;

  // uart_done may be held for many cycles; only its rising edge carries a byte.
  assign byte_edge  = uart_done & ~done_q;
  assign count_next = (&word_count) ? word_count : word_count + (ADDR_WIDTH+1)'(1);

  assign busy      = (state_q == RECV) || (state_q == FLUSH);
  assign load_done = (state_q == DONE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    flush   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en && byte_edge) begin
          accept  = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        // Abort beats a simultaneous byte; a byte beats a simultaneous timeout.
        if (!load_en) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (byte_edge) begin
          accept = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d = (byte_idx != 2'd0) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!load_en) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: reset clears every register, including the packing buffer and previous uart_done.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      done_q     <= 1'b0;
      byte_idx   <= 2'd0;
      word_buf   <= '0;
      timer_q    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
    end else begin
      done_q  <= uart_done;
      wr_en   <= 1'b0;
      timer_q <= (state_q == RECV && state_d == RECV && !accept) ? timer_q + TIMER_W'(1) : '0;

      // The address holds through the strobe cycle and advances right after it.
      if (wr_en) wr_addr <= wr_addr + ADDR_WIDTH'(1);

      if (accept) begin
        if (byte_idx == 2'd3) begin
          wr_data    <= {uart_data, word_buf[23:0]};
          wr_en      <= 1'b1;
          word_buf   <= '0;
          byte_idx   <= 2'd0;
          word_count <= count_next;
        end else begin
          word_buf[{byte_idx, 3'b000} +: 8] <= uart_data;
          byte_idx <= byte_idx + 2'd1;
        end
      end

      if (flush) begin
        wr_data    <= word_buf;
        wr_en      <= 1'b1;
        word_buf   <= '0;
        byte_idx   <= 2'd0;
        word_count <= count_next;
      end

      if (clear) begin
        wr_addr    <= '0;
        word_count <= '0;
        word_buf   <= '0;
        byte_idx   <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: stimulus pushes expected writes from a
// byte-list reference model; a monitor pops and compares on every wr_en.
module tb_uart_word_loader;

  localparam int AW = 4;
  localparam int TO = 100;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          load_en;
  logic          uart_done;
  logic [7:0]    uart_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          load_done;
  logic [AW:0]   word_count;

  uart_word_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load_en   (load_en),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .load_done (load_done),
    .word_count(word_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] pending[$];
  int         words;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a list of bytes for the current load; every four make a word.
  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    pending.push_back(b);
    if (pending.size() == 4) begin
      w.addr = words % (1 << AW);
      w.data = {pending[3], pending[2], pending[1], pending[0]};
      exp_q.push_back(w);
      words++;
      pending.delete();
    end
  endtask

  task automatic model_flush();
    wr_t w;
    if (pending.size() != 0) begin
      w.addr = words % (1 << AW);
      w.data = '0;
      for (int i = 0; i < pending.size(); i++) w.data[8*i +: 8] = pending[i];
      exp_q.push_back(w);
      words++;
      pending.delete();
    end
  endtask

  task automatic model_clear();
    pending.delete();
    words = 0;
  endtask

  function automatic int exp_count();
    return (words > (1 << (AW+1)) - 1) ? (1 << (AW+1)) - 1 : words;
  endfunction

  // Byte accepted on the first edge after the drive; held for h edges.
  task automatic send_byte(input logic [7:0] b, input int h, input bit accepted);
    @(posedge sys_clk);
    #1;
    uart_done = 1'b1;
    uart_data = b;
    if (accepted) model_byte(b);
    repeat (h) @(posedge sys_clk);
    #1;
    uart_done = 1'b0;
    uart_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
  endtask

  task automatic set_load_en(input logic v);
    @(posedge sys_clk);
    #1;
    load_en = v;
  endtask

  task automatic send_random(input int n, output int last_h);
    int h;
    h = 1;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(1, 4);
      send_byte(8'($urandom), h, 1'b1);
      if (i != n - 1) idle($urandom_range(0, 3));
    end
    last_h = h;
  endtask

  // Called straight after the last byte (held h cycles); checks the exact timeout edge.
  task automatic expect_timeout(input int h);
    bit rem;
    rem = (pending.size() != 0);
    model_flush();
    repeat (TO - h) @(posedge sys_clk);
    @(negedge sys_clk);
    check("pre_timeout_busy", 32'(busy), 32'd1);
    check("pre_timeout_done", 32'(load_done), 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (rem) begin
      check("flush_busy", 32'(busy), 32'd1);
      check("flush_done", 32'(load_done), 32'd0);
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    check("timeout_load_done", 32'(load_done), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_word_count", 32'(word_count), 32'(exp_count()));
  endtask

  task automatic end_load();
    set_load_en(1'b0);
    model_clear();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("idle_load_done", 32'(load_done), 32'd0);
    check("idle_word_count", 32'(word_count), 32'd0);
    check("idle_wr_addr", 32'(wr_addr), 32'd0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge sys_clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0d data=0x%08h required=no write", wr_addr, wr_data);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(w.addr));
          check("wr_data", wr_data, w.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] two_words [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] partial   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int last_h;

    checks    = 0;
    errors    = 0;
    words     = 0;
    sys_rst   = 1'b1;
    load_en   = 1'b0;
    uart_done = 1'b0;
    uart_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);

    // Two full words, uart_done held 3 cycles per byte.
    set_load_en(1'b1);
    foreach (two_words[i]) send_byte(two_words[i], 3, 1'b1);
    expect_timeout(3);
    end_load();

    // Partial final word is zero-padded by FLUSH.
    set_load_en(1'b1);
    foreach (partial[i]) send_byte(partial[i], 3, 1'b1);
    expect_timeout(3);

    // Bytes in DONE are ignored.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(1, 4), 1'b0);
    @(negedge sys_clk);
    check("done_ignore_load_done", 32'(load_done), 32'd1);
    check("done_ignore_count", 32'(word_count), 32'd2);
    end_load();

    // Abort mid-word, then a fresh word lands at address 0.
    set_load_en(1'b1);
    send_byte(8'hAA, 2, 1'b1);
    send_byte(8'hBB, 2, 1'b1);
    set_load_en(1'b0);
    model_clear();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_load_done", 32'(load_done), 32'd0);
    set_load_en(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2, 1'b1);

    // Next byte edge lands exactly on the expiry edge: stays in RECV.
    idle(TO - 1 - 2);
    send_byte(8'($urandom), 2, 1'b1);
    @(negedge sys_clk);
    check("edge_on_timeout_busy", 32'(busy), 32'd1);
    check("edge_on_timeout_done", 32'(load_done), 32'd0);

    // A 50-cycle uart_done gives one byte only.
    send_byte(8'($urandom), 50, 1'b1);
    send_random(5, last_h);
    expect_timeout(last_h);
    end_load();

    // 17 words: the 17th wraps to address 0, count keeps going.
    set_load_en(1'b1);
    send_random(68, last_h);
    expect_timeout(last_h);
    check("wrap_word_count", 32'(word_count), 32'd17);
    end_load();

    // Random-length loads.
    for (int l = 0; l < 3; l++) begin
      set_load_en(1'b1);
      send_random($urandom_range(1, 12), last_h);
      expect_timeout(last_h);
      end_load();
    end

    // Reset mid-word clears everything.
    set_load_en(1'b1);
    send_byte(8'($urandom), 2, 1'b1);
    send_byte(8'($urandom), 2, 1'b1);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    model_clear();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", wr_data, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_load_done", 32'(load_done), 32'd0);
    check("midrst_word_count", 32'(word_count), 32'd0);
    send_random(4, last_h);
    expect_timeout(last_h);

    idle(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Downstream consumer of the UART receiver in the program-load path. Takes received bytes (`uart_done` / `uart_data`) and packs them little-endian into 32-bit words. Writes each word to instruction memory through a single-cycle write port with an auto-incrementing word address. An idle-line timeout ends the load: a partial final word is zero-padded and written, then completion is flagged.

## Interface
Parameters:
- `ADDR_WIDTH`, 14, word-address width of the memory write port
- `TIMEOUT_CYCLES`, 5_000_000, idle `sys_clk` cycles after the last byte that end a load (1 s at 5 MHz)

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge
- `sys_rst`  in  1  synchronous, active-high reset
- `load_en`  in  1  level; high enables loading, low aborts or re-arms
- `uart_done`  in  1  receiver frame-done; may stay high for several cycles per byte
- `uart_data`  in  8  received byte; valid while `uart_done` is high
- `wr_en`  out  1  one-cycle memory write strobe
- `wr_addr`  out  ADDR_WIDTH  word address for `wr_en`
- `wr_data`  out  32  word for `wr_en`; byte 0 in [7:0]
- `busy`  out  1  high in RECV and FLUSH
- `load_done`  out  1  high in DONE
- `word_count`  out  ADDR_WIDTH+1  words written this load; saturates at all-ones

## Operation
- **Byte acceptance:** a byte is accepted on a cycle where `uart_done`=1 and the registered previous `uart_done`=0 (rising edge). Holding `uart_done` high never gives a second acceptance. Bytes are accepted only in IDLE or RECV with `load_en`=1.
- **Packing:** an internal 2-bit `byte_idx` selects the lane, `buf[8*byte_idx +: 8]` <= `uart_data`.
  - When `byte_idx`=3: load the `wr_data` register with the completed word, pulse `wr_en`, clear `buf` to 0, and set `byte_idx` to 0.
  - Otherwise `byte_idx` increments.
- **Address:** after each write, `wr_addr` increments modulo 2^ADDR_WIDTH (wraps to 0 with no error). `word_count` increments after each write and saturates.
- **States:**
  - **IDLE:** address, `byte_idx`, `buf`, timer and `word_count` are zero. An accepted byte goes to RECV; that byte is lane 0.
  - **RECV:** the timer counts cycles since the last accepted byte and clears on every accepted byte.
    - When the timer reaches TIMEOUT_CYCLES-1: go to FLUSH if `byte_idx`≠0, else go to DONE.
    - `load_en`=0 goes to IDLE: the partial word is discarded, there is no write, and `load_done` stays 0.
  - **FLUSH:** one cycle. Writes `buf` with unfilled lanes already zero, advances address and count, then goes to DONE.
  - **DONE:** bytes are ignored. Stays here until `load_en`=0, then goes to IDLE, clearing address and count.
- **Simultaneous events:**
  - Byte edge and timeout expiry in the same cycle: the byte wins and the timer clears.
  - `load_en`=0 and a byte edge in RECV in the same cycle: the abort wins and there is no write.
- **Reset** (any state, including mid-word): every output goes to 0, state to IDLE, internal registers to 0, and the previous-`uart_done` register to 0. A `uart_done` already high when reset releases therefore counts as an edge.

## Timing
- `wr_en`, `wr_addr`, `wr_data` are registered. `wr_en` is high for exactly the one cycle after the clock edge that accepted byte 3 (or the FLUSH cycle).
- `wr_addr` and `wr_data` are stable during that cycle. `wr_addr` advances on the following edge.
- Latency from the 4th byte's `uart_done` rising edge to `wr_en`=1: 1 cycle.
- Timeout: with the last byte accepted at edge T:
  - no remainder: DONE entered at edge T+TIMEOUT_CYCLES
  - remainder: FLUSH entered at that edge, FLUSH-cycle `wr_en` in the cycle after it, DONE one edge later
- `busy` and `load_done` are decoded from registered state with no combinational path from inputs. Minimum byte spacing is 2 cycles; the UART rate guarantees far more.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `load_done`=0, `word_count`=0.

## Test plan
All scenarios use TIMEOUT_CYCLES=100 and ADDR_WIDTH=4.
- **Two full words:** `load_en`=1; bytes 0x13,0x00,0x00,0x00,0xEF,0xBE,0xAD,0xDE with `uart_done` held 3 cycles each → writes (addr 0, 0x00000013) and (addr 1, 0xDEADBEEF), one `wr_en` pulse each. After 100 idle cycles `load_done`=1, `word_count`=2.
- **Partial final word:** bytes 0x11,0x22,0x33,0x44,0x55,0x66 → (0, 0x44332211). After the timeout, FLUSH writes (1, 0x00006655), then `load_done`=1, `word_count`=2.
- **Abort mid-word:** after 0xAA,0xBB, drop `load_en` → no `wr_en`, IDLE, `load_done`=0. Re-enable and send 4 bytes → the word is written at addr 0.
- **Edge cases:**
  - a byte edge on the exact timeout cycle keeps RECV, with no FLUSH
  - `uart_done` held 50 cycles gives one byte only
  - bytes arriving in DONE are ignored (`wr_en` stays 0)
- **Wrap and saturation:** 17 words with ADDR_WIDTH=4 → the 17th write goes to addr 0, and `word_count`=17 (5-bit, no saturation yet). Then pulse `sys_rst` mid-word → all outputs 0 on the next cycle.
